vram_rect_fill: RTL and testbench

Hardware rectangle-fill engine that produces the pixel-write stream for one write port of the VRAM write arbiter. It sits directly upstream of that arbiter, on port a or port b. It accepts one fill command (origin, size, colour), clips it to the 640x480 frame, and emits one registered write per pixel in raster order. A grant input stalls the stream while the arbiter serves the other port.

---
 rtl/vram_rect_fill.sv | 131 +++++++++++++
 tb/tb_vram_rect_fill.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/vram_rect_fill.sv
// Rectangle-fill engine: clips one fill command to the frame and streams one
// registered VRAM write per pixel in raster order, stalling while gnt is low.
module vram_rect_fill #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int AW    = 19,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [9:0]    x0,
    input  logic [9:0]    y0,
    input  logic [9:0]    w,
    input  logic [9:0]    h,
    input  logic [DW-1:0] color,
    input  logic          gnt,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] dwrite,
    output logic          wr,
    output logic          busy,
    output logic          done
);

    localparam logic [0:0]    ST_IDLE = 1'b0;
    localparam logic [0:0]    ST_FILL = 1'b1;
    localparam logic [10:0]   H_LIM   = 11'(H_RES);
    localparam logic [10:0]   V_LIM   = 11'(V_RES);
    localparam logic [AW-1:0] H_STEP  = AW'(H_RES);

    logic [0:0]    state_r;
    logic [9:0]    x_r;
    logic [9:0]    y_r;
    logic [9:0]    x0_r;
    logic [10:0]   x_end_r;
    logic [10:0]   y_end_r;
    logic [AW-1:0] row_base_r;

    logic [10:0]   x_sum_s;
    logic [10:0]   y_sum_s;
    logic [10:0]   x_end_s;
    logic [10:0]   y_end_s;
    logic          degenerate_s;
    logic [AW-1:0] y0_ext_s;
    logic [AW-1:0] row_start_s;
    logic [AW-1:0] row_next_s;
    logic          x_more_s;
    logic          y_more_s;

    // 11-bit sums cannot wrap, so the clip is a plain min against the frame size.
    assign x_sum_s      = {1'b0, x0} + {1'b0, w};
    assign y_sum_s      = {1'b0, y0} + {1'b0, h};
    assign x_end_s      = (x_sum_s > H_LIM) ? H_LIM : x_sum_s;
    assign y_end_s      = (y_sum_s > V_LIM) ? V_LIM : y_sum_s;
    assign degenerate_s = (w == 10'd0) || (h == 10'd0) ||
                          ({1'b0, x0} >= H_LIM) || ({1'b0, y0} >= V_LIM);

    // y0*640 as (y0<<9)+(y0<<7); only meaningful once y0 is known to be in frame.
    assign y0_ext_s     = AW'(y0);
    assign row_start_s  = (y0_ext_s << 9) + (y0_ext_s << 7);
    assign row_next_s   = row_base_r + H_STEP;

    assign x_more_s     = (11'(x_r) + 11'd1) < x_end_r;
    assign y_more_s     = (11'(y_r) + 11'd1) < y_end_r;

    // Command capture, raster walk and registered write-port outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= ST_IDLE;
            x_r        <= 10'd0;
            y_r        <= 10'd0;
            x0_r       <= 10'd0;
            x_end_r    <= 11'd0;
            y_end_r    <= 11'd0;
            row_base_r <= '0;
            addr       <= '0;
            dwrite     <= '0;
            wr         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        dwrite <= color;
                        if (degenerate_s) begin
                            done <= 1'b1;
                        end else begin
                            state_r    <= ST_FILL;
                            busy       <= 1'b1;
                            wr         <= 1'b1;
                            x_r        <= x0;
                            y_r        <= y0;
                            x0_r       <= x0;
                            x_end_r    <= x_end_s;
                            y_end_r    <= y_end_s;
                            row_base_r <= row_start_s;
                            addr       <= row_start_s + AW'(x0);
                        end
                    end
                end
                ST_FILL: begin
                    // gnt low holds every output; the pixel is retried next cycle.
                    if (gnt) begin
                        if (x_more_s) begin
                            x_r  <= x_r + 10'd1;
                            addr <= addr + AW'(1);
                        end else if (y_more_s) begin
                            x_r        <= x0_r;
                            y_r        <= y_r + 10'd1;
                            row_base_r <= row_next_s;
                            addr       <= row_next_s + AW'(x0_r);
                        end else begin
                            state_r <= ST_IDLE;
                            wr      <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    wr      <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_rect_fill.sv
// Directed bench for vram_rect_fill: fills, clipping, degenerate commands,
// gnt stalls, start handling and asynchronous reset during a fill.
module tb_vram_rect_fill;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [9:0]  x0;
    logic [9:0]  y0;
    logic [9:0]  w;
    logic [9:0]  h;
    logic [15:0] color;
    logic        gnt;
    logic [18:0] addr;
    logic [15:0] dwrite;
    logic        wr;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;
    int got_q[$];

    vram_rect_fill #(.H_RES(640), .V_RES(480), .AW(19), .DW(16)) dut (
        .clk(clk), .rstn(rstn), .start(start), .x0(x0), .y0(y0), .w(w), .h(h),
        .color(color), .gnt(gnt), .addr(addr), .dwrite(dwrite), .wr(wr),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start pulse, then scramble the command inputs to prove they are latched.
    task automatic cmd(input logic [9:0] cx, input logic [9:0] cy, input logic [9:0] cw,
                       input logic [9:0] ch, input logic [15:0] cc);
        x0 = cx; y0 = cy; w = cw; h = ch; color = cc; start = 1'b1;
        tick();
        start = 1'b0; x0 = 10'd999; y0 = 10'd999; w = 10'd7; h = 10'd7; color = 16'hAAAA;
    endtask

    // Collect writes with gnt high until wr drops; optionally pulse start mid-fill.
    task automatic drain(input int inject_at, input logic [15:0] exp_col);
        int cyc = 0;
        int bad = 0;
        got_q.delete();
        gnt = 1'b1;
        while (wr && cyc < 300) begin
            got_q.push_back(int'(addr));
            if (dwrite !== exp_col) bad++;
            if (got_q.size() == inject_at) begin
                x0 = 10'd5; y0 = 10'd5; w = 10'd3; h = 10'd3; color = 16'h5555; start = 1'b1;
            end
            tick();
            start = 1'b0;
            cyc++;
        end
        check("drain_bounded", 32'(cyc < 300), 32'd1);
        check("drain_dwrite", 32'(bad), 32'd0);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; gnt = 1'b1;
        x0 = 10'd0; y0 = 10'd0; w = 10'd0; h = 10'd0; color = 16'd0;
        #12;
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_dwrite", 32'(dwrite), 32'd0);
        check("rst_wr", 32'(wr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rstn = 1'b1;
        tick();

        // Basic 2x2 at (1,1).
        cmd(10'd1, 10'd1, 10'd2, 10'd2, 16'hF800);
        check("basic_busy", 32'(busy), 32'd1);
        drain(-1, 16'hF800);
        check("basic_count", 32'(got_q.size()), 32'd4);
        if (got_q.size() == 4) begin
            check("basic_a0", 32'(got_q[0]), 32'd641);
            check("basic_a1", 32'(got_q[1]), 32'd642);
            check("basic_a2", 32'(got_q[2]), 32'd1281);
            check("basic_a3", 32'(got_q[3]), 32'd1282);
        end
        check("basic_done", 32'(done), 32'd1);
        check("basic_busy_fall", 32'(busy), 32'd0);
        tick();
        check("basic_done_once", 32'(done), 32'd0);
        check("basic_dwrite_hold", 32'(dwrite), 32'hF800);

        // Clipping at the bottom-right corner.
        cmd(10'd638, 10'd479, 10'd5, 10'd3, 16'h07E0);
        drain(-1, 16'h07E0);
        check("clip_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check("clip_a0", 32'(got_q[0]), 32'd307198);
            check("clip_a1", 32'(got_q[1]), 32'd307199);
        end
        check("clip_done", 32'(done), 32'd1);
        tick();

        // Degenerate commands: w=0, then x0 off-frame.
        cmd(10'd3, 10'd3, 10'd0, 10'd4, 16'h001F);
        check("degw_wr", 32'(wr), 32'd0);
        check("degw_busy", 32'(busy), 32'd0);
        check("degw_done", 32'(done), 32'd1);
        tick();
        check("degw_done_end", 32'(done), 32'd0);
        check("degw_wr_after", 32'(wr), 32'd0);
        cmd(10'd700, 10'd3, 10'd4, 10'd4, 16'h001F);
        check("degx_wr", 32'(wr), 32'd0);
        check("degx_busy", 32'(busy), 32'd0);
        check("degx_done", 32'(done), 32'd1);
        tick();
        check("degx_done_end", 32'(done), 32'd0);

        // Stall: 3x1 at (10,20), gnt pattern 1,0,0,1,0,1.
        cmd(10'd10, 10'd20, 10'd3, 10'd1, 16'h1234);
        check("stall_a_first", 32'(addr), 32'd12810);
        gnt = 1'b1; tick(); check("stall_a_g1", 32'(addr), 32'd12811);
        gnt = 1'b0; tick(); check("stall_a_g0a", 32'(addr), 32'd12811);
        gnt = 1'b0; tick(); check("stall_a_g0b", 32'(addr), 32'd12811);
        check("stall_wr_hold", 32'(wr), 32'd1);
        gnt = 1'b1; tick(); check("stall_a_g1b", 32'(addr), 32'd12812);
        gnt = 1'b0; tick(); check("stall_a_g0c", 32'(addr), 32'd12812);
        check("stall_wr_hold2", 32'(wr), 32'd1);
        gnt = 1'b1; tick();
        check("stall_wr_end", 32'(wr), 32'd0);
        check("stall_done", 32'(done), 32'd1);

        // Start mid-fill ignored; start during the done cycle accepted.
        tick();
        cmd(10'd0, 10'd0, 10'd4, 10'd2, 16'h4321);
        drain(2, 16'h4321);
        check("midstart_count", 32'(got_q.size()), 32'd8);
        if (got_q.size() == 8) check("midstart_last", 32'(got_q[7]), 32'd643);
        check("midstart_done", 32'(done), 32'd1);
        cmd(10'd2, 10'd0, 10'd1, 10'd1, 16'h0F0F);
        check("donestart_wr", 32'(wr), 32'd1);
        check("donestart_addr", 32'(addr), 32'd2);
        check("donestart_dwrite", 32'(dwrite), 32'h0F0F);
        check("donestart_done_once", 32'(done), 32'd0);
        tick();
        check("donestart_done2", 32'(done), 32'd1);
        check("donestart_wr_end", 32'(wr), 32'd0);
        tick();

        // Asynchronous reset in the middle of a 10x10 fill.
        cmd(10'd0, 10'd0, 10'd10, 10'd10, 16'hFFFF);
        tick(); tick(); tick();
        check("rmid_busy_pre", 32'(busy), 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("rmid_wr", 32'(wr), 32'd0);
        check("rmid_busy", 32'(busy), 32'd0);
        check("rmid_done", 32'(done), 32'd0);
        check("rmid_addr", 32'(addr), 32'd0);
        #1 rstn = 1'b1;
        tick();
        check("rmid_no_done", 32'(done), 32'd0);
        check("rmid_wr_after", 32'(wr), 32'd0);
        cmd(10'd0, 10'd0, 10'd1, 10'd1, 16'h00FF);
        check("post_wr", 32'(wr), 32'd1);
        check("post_addr", 32'(addr), 32'd0);
        tick();
        check("post_done", 32'(done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
